// File: rtl/ptp_delay_estimator.sv
// Converts PTP round-trip counts to one-way delays, range/outlier-checks them,
// and publishes a block average over 2^AVG_LOG2 accepted samples.
module ptp_delay_estimator #(
  parameter int unsigned AVG_LOG2    = 3,
  parameter int unsigned PROC_OFFSET = 50,
  parameter int unsigned MIN_RTT     = 100,
  parameter int unsigned MAX_RTT     = 2000000,
  parameter int unsigned OUTLIER_TOL = 1000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        rtt_valid_i,
  input  logic [31:0] rtt_count_i,
  output logic        delay_valid_o,
  output logic [31:0] delay_avg_o,
  output logic [31:0] delay_last_o,
  output logic [15:0] sample_count_o,
  output logic [15:0] reject_count_o,
  output logic        locked_o,
  output logic        overrun_o,
  output logic [1:0]  state_o
);

  // Handshake: rtt_valid_i is a one-cycle strobe with no ready. It is taken
  // only in IDLE; a strobe in any other state is dropped and sets overrun_o.

  localparam int unsigned ACC_W = 32 + AVG_LOG2;
  localparam logic [31:0] PROC_W = 32'(PROC_OFFSET);
  localparam logic [31:0] MIN_W  = 32'(MIN_RTT);
  localparam logic [31:0] MAX_W  = 32'(MAX_RTT);
  localparam logic [31:0] TOL_W  = 32'(OUTLIER_TOL);

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM, PUBLISH} state_t;

  state_t              state_q;
  logic [31:0]         rtt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [AVG_LOG2-1:0] win_cnt_q;
  logic                delay_valid_q;
  logic [31:0]         delay_avg_q;
  logic [31:0]         delay_last_q;
  logic [15:0]         sample_count_q;
  logic [15:0]         reject_count_q;
  logic                locked_q;
  logic                overrun_q;

  logic [31:0] one_way;
  logic [31:0] diff;
  logic        reject;

  assign one_way = (rtt_q - PROC_W) >> 1;
  assign diff    = (one_way >= delay_avg_q) ? (one_way - delay_avg_q)
                                            : (delay_avg_q - one_way);
  // Outlier gate only applies once a window has been published.
  assign reject  = (rtt_q < MIN_W) || (rtt_q > MAX_W) ||
                   (locked_q && (diff > TOL_W));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      rtt_q          <= '0;
      acc_q          <= '0;
      win_cnt_q      <= '0;
      delay_valid_q  <= 1'b0;
      delay_avg_q    <= '0;
      delay_last_q   <= '0;
      sample_count_q <= '0;
      reject_count_q <= '0;
      locked_q       <= 1'b0;
      overrun_q      <= 1'b0;
    end else if (!enable_i) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      win_cnt_q     <= '0;
      delay_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      delay_valid_q <= 1'b0;
      if (rtt_valid_i && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (rtt_valid_i) begin
            rtt_q   <= rtt_count_i;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (reject) begin
            if (reject_count_q != 16'hFFFF) reject_count_q <= reject_count_q + 16'd1;
            state_q <= IDLE;
          end else begin
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q        <= acc_q + {{AVG_LOG2{1'b0}}, one_way};
          delay_last_q <= one_way;
          if (sample_count_q != 16'hFFFF) sample_count_q <= sample_count_q + 16'd1;
          win_cnt_q    <= win_cnt_q + 1'b1;
          state_q      <= (win_cnt_q == '1) ? PUBLISH : IDLE;
        end
        PUBLISH: begin
          delay_avg_q   <= acc_q[AVG_LOG2 +: 32];
          delay_valid_q <= 1'b1;
          locked_q      <= 1'b1;
          acc_q         <= '0;
          win_cnt_q     <= '0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign delay_valid_o  = delay_valid_q;
  assign delay_avg_o    = delay_avg_q;
  assign delay_last_o   = delay_last_q;
  assign sample_count_o = sample_count_q;
  assign reject_count_o = reject_count_q;
  assign locked_o       = locked_q;
  assign overrun_o      = overrun_q;
  assign state_o        = state_q;

endmodule
